// File: rtl/layer_feeder_pkg.sv
// Shared types and helpers for the layer feeder: FSM state encoding and counter sizing.
package layer_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        HOLD
    } feeder_state_e;

    // Width able to hold every value 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/layer_feeder_if.sv
// Bus bundle for the layer feeder: upstream word stream, neuron drive/observe bus, downstream result handshake.
interface layer_feeder_if #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
);
    logic [dataWidth-1:0]            in_data;
    logic                            in_valid;
    logic                            in_last;
    logic                            in_ready;
    logic [dataWidth-1:0]            myinput;
    logic                            freeze;
    logic                            pause;
    logic [numNeurons*dataWidth-1:0] n_out;
    logic [numNeurons*dataWidth-1:0] out_data;
    logic                            out_valid;
    logic                            out_ready;
    logic                            frame_err;

    modport master (
        input  in_data, in_valid, in_last, n_out, out_ready,
        output in_ready, myinput, freeze, pause, out_data, out_valid, frame_err
    );

    modport slave (
        output in_data, in_valid, in_last, n_out, out_ready,
        input  in_ready, myinput, freeze, pause, out_data, out_valid, frame_err
    );
endinterface

// File: rtl/layer_feeder.sv
// Streams one frame of words onto the shared neuron bus, then freezes the layer and
// offers the captured neuron outputs downstream.
//
//   state  | meaning
//   IDLE   | neurons frozen, waiting for the first word of a frame
//   STREAM | presenting words; pause on upstream bubbles
//   FLUSH  | one frozen cycle, neuron sums final, capture n_out
//   HOLD   | result offered downstream until accepted
module layer_feeder
    import layer_feeder_pkg::*;
#(
    parameter int numInputs  = 784,
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    layer_feeder_if.master bus
);

    localparam int            CW   = cnt_width(numInputs);
    localparam logic [CW-1:0] LAST = CW'(numInputs);

    feeder_state_e                   state_q, state_d;
    logic [CW-1:0]                   count_q, count_d;
    logic [dataWidth-1:0]            myinput_q, myinput_d;
    logic                            freeze_q, freeze_d;
    logic                            pause_q, pause_d;
    logic [numNeurons*dataWidth-1:0] out_data_q, out_data_d;
    logic                            out_valid_q, out_valid_d;
    logic                            frame_err_q, frame_err_d;

    logic          in_ready;
    logic          accept;
    logic [CW-1:0] count_inc;

    // Registers only, so upstream may legally wait for ready before raising valid.
    assign in_ready  = (state_q == IDLE) || ((state_q == STREAM) && (count_q < LAST));
    assign accept    = bus.in_valid & in_ready;
    assign count_inc = count_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        myinput_d   = myinput_q;
        freeze_d    = freeze_q;
        pause_d     = pause_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frame_err_d = frame_err_q;

        case (state_q)
            IDLE: begin
                freeze_d = 1'b1;
                pause_d  = 1'b1;
                count_d  = '0;
                if (accept) begin
                    myinput_d = bus.in_data;
                    freeze_d  = 1'b0;
                    pause_d   = 1'b0;
                    count_d   = CW'(1);
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                if (count_q == LAST) begin
                    freeze_d = 1'b1;
                    pause_d  = 1'b1;
                    state_d  = FLUSH;
                end else if (accept) begin
                    myinput_d = bus.in_data;
                    pause_d   = 1'b0;
                    count_d   = count_inc;
                end else begin
                    pause_d = 1'b1;
                end
            end
            FLUSH: begin
                out_data_d  = bus.n_out;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // in_last is advisory; the frame length is always set by the counter.
        if (accept && (bus.in_last != (count_inc == LAST)))
            frame_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            myinput_q   <= '0;
            freeze_q    <= 1'b1;
            pause_q     <= 1'b1;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            myinput_q   <= myinput_d;
            freeze_q    <= freeze_d;
            pause_q     <= pause_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.myinput   = myinput_q;
    assign bus.freeze    = freeze_q;
    assign bus.pause     = pause_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_layer_feeder.sv
// Directed bench for layer_feeder driving a two-neuron behavioural layer with four-word frames.
module tb_layer_feeder;

    localparam int NI = 4;
    localparam int NN = 2;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    layer_feeder_if #(.numNeurons(NN), .dataWidth(DW)) bus ();

    layer_feeder #(.numInputs(NI), .numNeurons(NN), .dataWidth(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int acc_edge = 0;

    always @(posedge clk) cyc++;

    // Behavioural neurons: freeze clears the address, word k meets weight k,
    // the first unpaused cycle of a frame overwrites the stale sum.
    localparam int W0[4] = '{1, 2, 3, 4};
    localparam int W1[4] = '{2, 0, 1, 3};
    logic [15:0] nsum0 = '0;
    logic [15:0] nsum1 = '0;
    logic [1:0]  naddr = '0;

    always @(posedge clk) begin
        if (bus.freeze) begin
            naddr <= '0;
        end else if (!bus.pause) begin
            nsum0 <= (naddr == 2'd0 ? 16'h0 : nsum0) + 16'(W0[naddr] * int'(bus.myinput));
            nsum1 <= (naddr == 2'd0 ? 16'h0 : nsum1) + 16'(W1[naddr] * int'(bus.myinput));
            naddr <= naddr + 2'd1;
        end
    end
    assign bus.n_out = {nsum1, nsum0};

    logic [15:0] seen[$];
    always @(negedge clk)
        if (rst_n && !bus.freeze && !bus.pause) seen.push_back(bus.myinput);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] w[4], input int last_idx,
                              input int gap_after, input int gap_len);
        seen.delete();
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            bus.in_data  = w[i];
            bus.in_valid = 1'b1;
            bus.in_last  = (i == last_idx);
            while (!bus.in_ready && n < 20) begin
                step;
                n++;
            end
            chk("in_ready_word", bus.in_ready, 1);
            step;
            if (i == 0) acc_edge = cyc;
            chk("myinput_word", bus.myinput, w[i]);
            chk("pause_word", bus.pause, 0);
            chk("freeze_word", bus.freeze, 0);
            if (i == gap_after) begin
                bus.in_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    step;
                    chk("pause_gap", bus.pause, 1);
                    chk("myinput_gap", bus.myinput, w[i]);
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic finish_frame(input logic [31:0] exp, input int exp_lat, input logic [15:0] w[4]);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            step;
            n++;
        end
        chk("latency", 64'(cyc - acc_edge), 64'(exp_lat));
        chk("out_data", bus.out_data, exp);
        chk("unpaused_count", 64'(seen.size()), 4);
        for (int k = 0; k < 4 && k < seen.size(); k++)
            chk("word_order", seen[k], w[k]);
        if (bus.out_ready) begin
            step;
            chk("out_valid_drop", bus.out_valid, 0);
            chk("idle_ready", bus.in_ready, 1);
        end
    endtask

    logic [15:0] fa[4];
    logic [15:0] fb[4];
    localparam logic [31:0] RES_A = 32'h8800_F000;
    localparam logic [31:0] RES_B = 32'h0011_001E;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        fa = '{16'h0800, 16'h1000, 16'h1800, 16'h2000};
        fb = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        step;
        step;
        chk("rst_freeze", bus.freeze, 1);
        chk("rst_pause", bus.pause, 1);
        chk("rst_myinput", bus.myinput, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        step;
        chk("idle_freeze", bus.freeze, 1);

        // continuous stream
        send_frame(fa, 3, -1, 0);
        chk("last_ready_low", bus.in_ready, 0);
        step;
        chk("flush_freeze", bus.freeze, 1);
        chk("flush_pause", bus.pause, 1);
        finish_frame(RES_A, 5, fa);
        chk("err_clean", bus.frame_err, 0);

        // two-cycle upstream bubble after the second word
        send_frame(fa, 3, 1, 2);
        finish_frame(RES_A, 7, fa);

        // downstream backpressure in HOLD
        bus.out_ready = 1'b0;
        send_frame(fb, 3, -1, 0);
        finish_frame(RES_B, 5, fb);
        for (int s = 0; s < 5; s++) begin
            step;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", bus.out_data, RES_B);
            chk("hold_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        step;
        chk("hold_release", bus.out_valid, 0);
        chk("hold_idle", bus.in_ready, 1);

        // early in_last
        chk("err_before", bus.frame_err, 0);
        send_frame(fa, 1, -1, 0);
        chk("err_set", bus.frame_err, 1);
        finish_frame(RES_A, 5, fa);
        chk("err_sticky", bus.frame_err, 1);

        // reset while word 3 is on the bus
        for (int i = 0; i < 3; i++) begin
            bus.in_data  = fb[i];
            bus.in_valid = 1'b1;
            step;
        end
        chk("abort_word3", bus.myinput, fb[2]);
        #2 rst_n = 1'b0;
        #1;
        chk("async_freeze", bus.freeze, 1);
        chk("async_pause", bus.pause, 1);
        chk("async_valid", bus.out_valid, 0);
        chk("async_err", bus.frame_err, 0);
        bus.in_valid = 1'b0;
        step;
        step;
        rst_n = 1'b1;
        step;
        send_frame(fa, 3, -1, 0);
        finish_frame(RES_A, 5, fa);

        // back-to-back frames
        send_frame(fb, 3, -1, 0);
        finish_frame(RES_B, 5, fb);
        send_frame(fa, 3, -1, 0);
        finish_frame(RES_A, 5, fa);
        chk("b2b_err", bus.frame_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
